// File: rtl/rf_sb.sv
// rf_sb: parametrised ID-stage register file with a per-register busy
// scoreboard.
//
// Reads are combinational. Write-back and the link port update on the
// rising edge of Clk. Issue marking sets busy bits, write-back clears them.
// Reset is synchronous and active-high. It clears all contents and all busy
// bits, and while it is asserted every output reads 0.
//
// Parameters:
//   WIDTH    data width of each register
//   AW       address width; DEPTH = 2**AW registers
//   LINK_REG index written by the link port
//   ZERO_REG 1 = register 0 reads 0, ignores writes and is never busy
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Ra, Rb              read addresses
//   BusA, BusB          read data
//   WrEn, Rw, BusW      write-back port; it also clears Busy[Rw]
//   LinkWr, LinkData    link write into LINK_REG; wins over write-back
//   IssueEn, IssueRd    marks the destination register busy
//   BusyA, BusyB        busy bit of Ra / Rb
//   BusyCnt             registered count of busy registers
//
// Optional feature: define RF_BYPASS_EN to enable write-through forwarding.
// With it, a same-cycle write-back or link write is visible on BusA/BusB,
// and a same-cycle write-back hides the busy bit. Without it, reads see
// only stored state.

module rf_sb #(
   parameter int WIDTH    = 32,
   parameter int AW       = 5,
   parameter int LINK_REG = 31,
   parameter int ZERO_REG = 1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [AW-1:0]    Ra,
   input  logic [AW-1:0]    Rb,
   output logic [WIDTH-1:0] BusA,
   output logic [WIDTH-1:0] BusB,
   input  logic             WrEn,
   input  logic [AW-1:0]    Rw,
   input  logic [WIDTH-1:0] BusW,
   input  logic             LinkWr,
   input  logic [WIDTH-1:0] LinkData,
   input  logic             IssueEn,
   input  logic [AW-1:0]    IssueRd,
   output logic             BusyA,
   output logic             BusyB,
   output logic [AW:0]      BusyCnt
);

   localparam int            DEPTH    = 2**AW;
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
   localparam bit            HAS_ZERO = (ZERO_REG != 0);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy, busy_nxt;
   logic [AW:0]      busy_cnt, cnt_nxt;
   logic             wb_en, link_en, set_en, cnt_inc, cnt_dec;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return HAS_ZERO && (a == '0);
   endfunction

   assign wb_en   = WrEn && !is_zero(Rw);
   assign link_en = LinkWr && !is_zero(LINK_IDX);
   assign set_en  = IssueEn && !is_zero(IssueRd);

   // The set is applied after the clear, so a new producer on the same
   // index keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (WrEn)   busy_nxt[Rw]      = 1'b0;
      if (set_en) busy_nxt[IssueRd] = 1'b1;
   end

   // The count is updated from the differences only, so it never has to
   // compute a popcount over DEPTH bits.
   assign cnt_inc = set_en && !busy[IssueRd];
   assign cnt_dec = WrEn && busy[Rw] && !(set_en && (IssueRd == Rw));

   always_comb begin
      cnt_nxt = busy_cnt;
      if (cnt_inc && !cnt_dec)      cnt_nxt = busy_cnt + (AW+1)'(1);
      else if (cnt_dec && !cnt_inc) cnt_nxt = busy_cnt - (AW+1)'(1);
   end

   // The link write comes last, so it overrides a write-back to LINK_REG.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         if (wb_en)   regs[Rw]       <= BusW;
         if (link_en) regs[LINK_IDX] <= LinkData;
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] a);
      logic [WIDTH-1:0] d;
      d = regs[a];
`ifdef RF_BYPASS_EN
      if (link_en && (a == LINK_IDX)) d = LinkData;
      else if (wb_en && (a == Rw))    d = BusW;
`endif
      if (Rst || is_zero(a)) d = '0;
      return d;
   endfunction

   function automatic logic rd_busy(input logic [AW-1:0] a);
      logic b;
      b = busy[a];
`ifdef RF_BYPASS_EN
      if (WrEn && (Rw == a) && !(set_en && (IssueRd == a))) b = 1'b0;
`endif
      if (Rst || is_zero(a)) b = 1'b0;
      return b;
   endfunction

   always_comb begin
      BusA    = rd_data(Ra);
      BusB    = rd_data(Rb);
      BusyA   = rd_busy(Ra);
      BusyB   = rd_busy(Rb);
      BusyCnt = Rst ? '0 : busy_cnt;
   end

endmodule

// File: tb/tb_rf_sb.sv
// Testbench for rf_sb with the default parameters (32 x 32, link register 31,
// register 0 hardwired to zero).
//
// The reference model keeps plain arrays of register values and busy flags.
// It updates them from the input rules at each rising edge, and BusyCnt is
// compared against a popcount of the busy flags. A single process compares
// every output against the model at each falling edge. Pinned literal
// expectations from the directed steps are checked in the same process.

module tb_rf_sb;
   localparam int W  = 32;
   localparam int AW = 5;
   localparam int N  = 32;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic [AW-1:0] Ra = '0, Rb = '0, Rw = '0, IssueRd = '0;
   logic [W-1:0]  BusW = '0, LinkData = '0;
   logic          WrEn = 1'b0, LinkWr = 1'b0, IssueEn = 1'b0;
   logic [W-1:0]  BusA, BusB;
   logic          BusyA, BusyB;
   logic [AW:0]   BusyCnt;

   int checks = 0;
   int errors = 0;
   logic check_en = 1'b0;

   logic pa_en = 1'b0, pba_en = 1'b0, pc_en = 1'b0;
   logic [W-1:0] pa_val = '0, pba_val = '0, pc_val = '0;

   logic [W-1:0] mreg  [N] = '{default: '0};
   bit           mbusy [N] = '{default: 1'b0};

   always #5 Clk = ~Clk;

   rf_sb #(.WIDTH(W), .AW(AW), .LINK_REG(31), .ZERO_REG(1)) dut (
      .Clk(Clk), .Rst(Rst), .Ra(Ra), .Rb(Rb), .BusA(BusA), .BusB(BusB),
      .WrEn(WrEn), .Rw(Rw), .BusW(BusW), .LinkWr(LinkWr), .LinkData(LinkData),
      .IssueEn(IssueEn), .IssueRd(IssueRd), .BusyA(BusyA), .BusyB(BusyB),
      .BusyCnt(BusyCnt)
   );

   always @(posedge Clk) begin
      if (Rst) begin
         foreach (mreg[i]) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
         end
      end else begin
         if (WrEn && Rw != 0) mreg[Rw] = BusW;
         if (LinkWr) mreg[31] = LinkData;
         if (WrEn) mbusy[Rw] = 1'b0;
         if (IssueEn && IssueRd != 0) mbusy[IssueRd] = 1'b1;
      end
   end

   function automatic int popcount();
      int c = 0;
      foreach (mbusy[i]) c += int'(mbusy[i]);
      return c;
   endfunction

   function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
      if (Rst || a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (LinkWr && a == 31) return LinkData;
      if (WrEn && a == Rw) return BusW;
`endif
      return mreg[a];
   endfunction

   function automatic logic [W-1:0] exp_busy(input logic [AW-1:0] a);
      if (Rst || a == 0) return '0;
`ifdef RF_BYPASS_EN
      if (WrEn && Rw == a && !(IssueEn && IssueRd == a)) return '0;
`endif
      return W'(mbusy[a]);
   endfunction

   task automatic cmp(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", nm, $time, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (check_en) begin
         cmp("BusA", BusA, exp_rd(Ra));
         cmp("BusB", BusB, exp_rd(Rb));
         cmp("BusyA", W'(BusyA), exp_busy(Ra));
         cmp("BusyB", W'(BusyB), exp_busy(Rb));
         cmp("BusyCnt", W'(BusyCnt), Rst ? '0 : W'(popcount()));
         if (pa_en)  cmp("pin_BusA", BusA, pa_val);
         if (pba_en) cmp("pin_BusyA", W'(BusyA), pba_val);
         if (pc_en)  cmp("pin_BusyCnt", W'(BusyCnt), pc_val);
      end
   end

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      WrEn = 1'b0; LinkWr = 1'b0; IssueEn = 1'b0;
      pa_en = 1'b0; pba_en = 1'b0; pc_en = 1'b0;
   endtask

   task automatic pin_a(input logic [W-1:0] v);   pa_en = 1'b1;  pa_val = v;  endtask
   task automatic pin_ba(input logic [W-1:0] v);  pba_en = 1'b1; pba_val = v; endtask
   task automatic pin_c(input logic [W-1:0] v);   pc_en = 1'b1;  pc_val = v;  endtask

   initial begin
      idle(); Rst = 1'b1;
      cyc(); cyc();
      Rst = 1'b0; check_en = 1'b1;

      // Reset: preload R5, mark R7 busy, then reset with enables active.
      idle(); WrEn = 1'b1; Rw = 5; BusW = 32'h1234; Ra = 5; Rb = 7; cyc();
      idle(); IssueEn = 1'b1; IssueRd = 7; Ra = 5; pin_a(32'h1234); pin_c(0); cyc();
      idle(); Ra = 7; Rb = 5; pin_ba(1); pin_c(1); cyc();
      idle(); Rst = 1'b1; WrEn = 1'b1; Rw = 6; BusW = 32'hDEAD; IssueEn = 1'b1;
      IssueRd = 4; Ra = 5; pin_a(0); pin_c(0); cyc();
      idle(); Rst = 1'b0; Ra = 5; Rb = 6; pin_a(0); pin_c(0); cyc();
      idle(); Ra = 7; Rb = 4; pin_ba(0); pin_c(0); cyc();
      idle(); Ra = 6; pin_a(0); cyc();

      // Register 0 ignores both the write and the issue.
      idle(); WrEn = 1'b1; Rw = 0; BusW = 32'hFFFF_FFFF; IssueEn = 1'b1; IssueRd = 0;
      Ra = 0; Rb = 0; pin_a(0); pin_c(0); cyc();
      idle(); Ra = 0; pin_a(0); pin_ba(0); pin_c(0); cyc();

      // The link port wins over a write-back to register 31.
      idle(); WrEn = 1'b1; Rw = 31; BusW = 32'hAAAA_0000; LinkWr = 1'b1;
      LinkData = 32'h0040_0010; Ra = 0; Rb = 1; cyc();
      idle(); Ra = 31; Rb = 31; pin_a(32'h0040_0010); cyc();

      // Scoreboard: issue, then write-back and re-issue together, then write-back alone.
      idle(); IssueEn = 1'b1; IssueRd = 3; Ra = 3; Rb = 2; pin_ba(0); pin_c(0); cyc();
      idle(); WrEn = 1'b1; Rw = 3; BusW = 32'h33; IssueEn = 1'b1; IssueRd = 3;
      Ra = 3; pin_ba(1); pin_c(1); cyc();
      idle(); Ra = 3; pin_ba(1); pin_c(1); pin_a(32'h33); cyc();
      idle(); WrEn = 1'b1; Rw = 3; BusW = 32'h34; Ra = 2; cyc();
      idle(); Ra = 3; pin_ba(0); pin_c(0); pin_a(32'h34); cyc();

      // Set and clear on different indices, re-issue of a busy register, and
      // write-back of a non-busy register.
      idle(); IssueEn = 1'b1; IssueRd = 3; cyc();
      idle(); IssueEn = 1'b1; IssueRd = 10; WrEn = 1'b1; Rw = 3; BusW = 32'h35;
      Ra = 10; Rb = 3; pin_c(1); cyc();
      idle(); Ra = 10; pin_ba(1); pin_c(1); cyc();
      idle(); IssueEn = 1'b1; IssueRd = 10; cyc();
      idle(); WrEn = 1'b1; Rw = 12; BusW = 32'h12; Ra = 12; pin_c(1); cyc();
      idle(); Ra = 12; pin_c(1); pin_a(32'h12); cyc();
      idle(); WrEn = 1'b1; Rw = 10; BusW = 32'h10; cyc();
      idle(); Ra = 10; pin_ba(0); pin_c(0); cyc();

      // Write-through: R9 holds 0x11 when 0x55 is written and read in the same cycle.
      idle(); WrEn = 1'b1; Rw = 9; BusW = 32'h11; Ra = 1; cyc();
      idle(); WrEn = 1'b1; Rw = 9; BusW = 32'h55; Ra = 9; Rb = 9;
`ifdef RF_BYPASS_EN
      pin_a(32'h55);
`else
      pin_a(32'h11);
`endif
      cyc();
      idle(); Ra = 9; pin_a(32'h55); cyc();

      // Fill: issue registers 1..31, then write back all of them.
      for (int i = 1; i < N; i++) begin
         idle(); IssueEn = 1'b1; IssueRd = AW'(i); Ra = AW'(i); Rb = AW'(i - 1);
         pin_c(W'(i - 1)); cyc();
      end
      idle(); Ra = 31; Rb = 1; pin_c(31); pin_ba(1); cyc();
      for (int i = 1; i < N; i++) begin
         idle(); WrEn = 1'b1; Rw = AW'(i); BusW = W'(i) << 8; Ra = AW'(i); Rb = AW'(N - i);
         pin_c(W'(N - i)); cyc();
      end
      idle(); Ra = 31; Rb = 16; pin_c(0); pin_ba(0); pin_a(32'h1F00); cyc();
      idle(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
